// File: rtl/fifo_pkg.sv
// Shared constants and parameter validation for the synchronous flag FIFO family.
// Every FIFO in this slice imports this package so legality rules live in one place.
package fifo_pkg;

    localparam int DEFAULT_DW           = 32;
    localparam int DEFAULT_DEPTH        = 16;
    localparam int DEFAULT_AEMPTY_TH    = 2;
    localparam int DEFAULT_AFULL_MARGIN = 2;
    localparam int DEFAULT_OUT_REG      = 0;

    localparam int MIN_DW    = 1;
    localparam int MAX_DW    = 256;
    localparam int MIN_DEPTH = 2;

    // almost_full default sits a fixed margin below the top of the buffer
    function automatic int default_afull_th(input int depth);
        return depth - DEFAULT_AFULL_MARGIN;
    endfunction

    function automatic bit threshold_ok(input int th, input int depth);
        return (th >= 1) && (th <= depth - 1);
    endfunction

    function automatic bit params_ok(
        input int dw,
        input int depth,
        input int afull_th,
        input int aempty_th,
        input int out_reg
    );
        bit ok;
        ok = 1'b1;
        if (dw < MIN_DW || dw > MAX_DW)        ok = 1'b0;
        if (depth < MIN_DEPTH)                  ok = 1'b0;
        if (!threshold_ok(afull_th, depth))     ok = 1'b0;
        if (!threshold_ok(aempty_th, depth))    ok = 1'b0;
        if (out_reg != 0 && out_reg != 1)       ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// AW-bit circular pointer that steps by one on inc and wraps from LIMIT back to zero.
// Used for both the write and the read side of the FIFO.
module fifo_wrap_ptr #(
    parameter int AW    = 4,
    parameter int LIMIT = 15
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    localparam logic [AW-1:0] LAST = AW'(LIMIT);
    localparam logic [AW-1:0] STEP = AW'(1);

    if (LIMIT < 1 || LIMIT > (2 ** AW) - 1) begin : g_limit_error
        $error("fifo_wrap_ptr: LIMIT=%0d does not fit in AW=%0d bits", LIMIT, AW);
    end

    // wrap is an explicit compare so non-power-of-two depths stay in range
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + STEP;
        end
    end

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy level, full/empty/almost flags and error pulses.
// OUT_REG selects a combinational head word or a registered, one-cycle-latency read port.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int DW        = DEFAULT_DW,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AFULL_TH  = default_afull_th(DEPTH),
    parameter int AEMPTY_TH = DEFAULT_AEMPTY_TH,
    parameter int OUT_REG   = DEFAULT_OUT_REG,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [DW-1:0] data_in,
    input  logic          rd_en,
    output logic [DW-1:0] data_out,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic          almost_empty,
    output logic          almost_full,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] LEVEL_DEPTH  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LEVEL_AFULL  = (AW + 1)'(AFULL_TH);
    localparam logic [AW:0] LEVEL_AEMPTY = (AW + 1)'(AEMPTY_TH);
    localparam logic [AW:0] LEVEL_ONE    = (AW + 1)'(1);

    if (!params_ok(DW, DEPTH, AFULL_TH, AEMPTY_TH, OUT_REG)) begin : g_param_error
        $error("fifo_sync_flags: illegal parameters DW=%0d DEPTH=%0d AFULL_TH=%0d AEMPTY_TH=%0d OUT_REG=%0d",
               DW, DEPTH, AFULL_TH, AEMPTY_TH, OUT_REG);
    end

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_acc;
    logic          wr_acc;

    // a read frees a slot in the same cycle, so a full FIFO can still take a write
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    fifo_wrap_ptr #(
        .AW    (AW),
        .LIMIT (DEPTH - 1)
    ) u_wr_ptr (
        .clk  (clk),
        .rstn (rstn),
        .inc  (wr_acc),
        .ptr  (wr_ptr)
    );

    fifo_wrap_ptr #(
        .AW    (AW),
        .LIMIT (DEPTH - 1)
    ) u_rd_ptr (
        .clk  (clk),
        .rstn (rstn),
        .inc  (rd_acc),
        .ptr  (rd_ptr)
    );

    // storage is deliberately not reset; a held reset still blocks writes
    always_ff @(posedge clk) begin
        if (rstn && wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            level <= '0;
        end else if (wr_acc && !rd_acc) begin
            level <= level + LEVEL_ONE;
        end else if (rd_acc && !wr_acc) begin
            level <= level - LEVEL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && !wr_acc;
            underflow <= rd_en && !rd_acc;
        end
    end

    assign empty        = (level == '0);
    assign full         = (level == LEVEL_DEPTH);
    assign almost_empty = (level <= LEVEL_AEMPTY);
    assign almost_full  = (level >= LEVEL_AFULL);

    if (OUT_REG == 0) begin : g_comb_out
        assign data_out = mem[rd_ptr];
        assign rd_valid = !empty;
    end else begin : g_reg_out
        logic [DW-1:0] data_q;
        logic          valid_q;

        // rd_valid marks the single cycle in which data_q carries a fresh word
        always_ff @(posedge clk) begin
            if (!rstn) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_acc;
                if (rd_acc) begin
                    data_q <= mem[rd_ptr];
                end
            end
        end

        assign data_out = data_q;
        assign rd_valid = valid_q;
    end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags: one instance per OUT_REG setting, driven in lockstep,
// checked against a queue model plus a table of explicit expected flag values.
module tb_fifo_sync_flags;

    localparam int DW        = 8;
    localparam int DEPTH     = 5;
    localparam int AFULL_TH  = 4;
    localparam int AEMPTY_TH = 1;

    logic          clk     = 1'b0;
    logic          rstn    = 1'b0;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] data_out_c, data_out_r;
    logic          rd_valid_c, rd_valid_r;
    logic          empty_c, empty_r, full_c, full_r;
    logic          aempty_c, aempty_r, afull_c, afull_r;
    logic [3:0]    level_c, level_r;
    logic          ovf_c, ovf_r, udf_c, udf_r;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sb [$];
    logic          exp_ovf   = 1'b0;
    logic          exp_udf   = 1'b0;
    logic          exp_rv_r  = 1'b0;
    logic [DW-1:0] exp_dout_r = '0;
    logic [DW-1:0] last_read = '0;

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       rd;
        logic [3:0] lvl;
        logic       full;
        logic       empty;
        logic       afull;
        logic       aempty;
        logic       ovf;
        logic       udf;
        logic [7:0] dout_r;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    fifo_sync_flags #(
        .DW(DW), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH), .OUT_REG(0)
    ) dut_c (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out_c), .rd_valid(rd_valid_c), .empty(empty_c), .full(full_c),
        .almost_empty(aempty_c), .almost_full(afull_c), .level(level_c),
        .overflow(ovf_c), .underflow(udf_c)
    );

    fifo_sync_flags #(
        .DW(DW), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH), .OUT_REG(1)
    ) dut_r (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out_r), .rd_valid(rd_valid_r), .empty(empty_r), .full(full_r),
        .almost_empty(aempty_r), .almost_full(afull_r), .level(level_r),
        .overflow(ovf_r), .underflow(udf_r)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        int lvl;
        lvl = sb.size();
        check("level_c", 32'(level_c), 32'(lvl));
        check("level_r", 32'(level_r), 32'(lvl));
        check("empty_c", 32'(empty_c), 32'(lvl == 0));
        check("empty_r", 32'(empty_r), 32'(lvl == 0));
        check("full_c", 32'(full_c), 32'(lvl == DEPTH));
        check("full_r", 32'(full_r), 32'(lvl == DEPTH));
        check("aempty_c", 32'(aempty_c), 32'(lvl <= AEMPTY_TH));
        check("aempty_r", 32'(aempty_r), 32'(lvl <= AEMPTY_TH));
        check("afull_c", 32'(afull_c), 32'(lvl >= AFULL_TH));
        check("afull_r", 32'(afull_r), 32'(lvl >= AFULL_TH));
        check("overflow_c", 32'(ovf_c), 32'(exp_ovf));
        check("overflow_r", 32'(ovf_r), 32'(exp_ovf));
        check("underflow_c", 32'(udf_c), 32'(exp_udf));
        check("underflow_r", 32'(udf_r), 32'(exp_udf));
        check("rd_valid_c", 32'(rd_valid_c), 32'(lvl != 0));
        check("rd_valid_r", 32'(rd_valid_r), 32'(exp_rv_r));
        check("data_out_r", 32'(data_out_r), 32'(exp_dout_r));
    endtask

    // called at a falling edge; drives one cycle and checks after the next falling edge
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r);
        logic rd_acc, wr_acc;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        #1;
        rd_acc = r && (sb.size() != 0);
        wr_acc = w && ((sb.size() != DEPTH) || rd_acc);
        exp_rv_r = rd_acc;
        if (rd_acc) begin
            last_read = sb.pop_front();
            check("head_c", 32'(data_out_c), 32'(last_read));
            exp_dout_r = last_read;
        end
        if (wr_acc) sb.push_back(d);
        exp_ovf = w && !wr_acc;
        exp_udf = r && !rd_acc;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        checkOutput();
    endtask

    task automatic doReset(input logic w, input logic r);
        rstn    = 1'b0;
        wr_en   = w;
        rd_en   = r;
        data_in = 8'h99;
        @(posedge clk);
        @(negedge clk);
        rstn  = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        sb.delete();
        exp_ovf    = 1'b0;
        exp_udf    = 1'b0;
        exp_rv_r   = 1'b0;
        exp_dout_r = '0;
        checkOutput();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 8'h12, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 8'h13, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 8'h14, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 8'h15, 1'b0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 8'h16, 1'b0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h13};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h14};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h15};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h15};

        @(negedge clk);
        doReset(1'b0, 1'b0);

        // fill past full, then drain past empty, against explicit table values
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].din, vecs[i].rd);
            check($sformatf("vec%0d_level", i), 32'(level_c), 32'(vecs[i].lvl));
            check($sformatf("vec%0d_full", i), 32'(full_r), 32'(vecs[i].full));
            check($sformatf("vec%0d_empty", i), 32'(empty_c), 32'(vecs[i].empty));
            check($sformatf("vec%0d_afull", i), 32'(afull_c), 32'(vecs[i].afull));
            check($sformatf("vec%0d_aempty", i), 32'(aempty_r), 32'(vecs[i].aempty));
            check($sformatf("vec%0d_ovf", i), 32'(ovf_c), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_udf", i), 32'(udf_r), 32'(vecs[i].udf));
            check($sformatf("vec%0d_dout_r", i), 32'(data_out_r), 32'(vecs[i].dout_r));
        end

        // two resident words, twelve paired transfers walk both pointers round twice
        applyStimulus(1'b1, 8'h20, 1'b0);
        applyStimulus(1'b1, 8'h21, 1'b0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 8'h30 + 8'(i), 1'b1);
            check("wrap_level", 32'(level_c), 32'd2);
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        check("wrap_last_read", 32'(last_read), 32'h3B);

        // simultaneous access at full
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'h41 + 8'(i), 1'b0);
        applyStimulus(1'b1, 8'hAA, 1'b1);
        check("full_rw_level", 32'(level_r), 32'd5);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        check("full_rw_last", 32'(last_read), 32'hAA);

        // simultaneous access at empty
        applyStimulus(1'b1, 8'h3C, 1'b1);
        check("empty_rw_level", 32'(level_c), 32'd1);
        check("empty_rw_udf", 32'(udf_c), 32'd1);
        check("empty_rw_head", 32'(data_out_c), 32'h3C);
        applyStimulus(1'b0, 8'h00, 1'b1);

        // reset with stored words, requests held high during reset
        applyStimulus(1'b1, 8'h51, 1'b0);
        applyStimulus(1'b1, 8'h52, 1'b0);
        applyStimulus(1'b1, 8'h53, 1'b0);
        doReset(1'b1, 1'b1);
        check("reset_level", 32'(level_r), 32'd0);
        applyStimulus(1'b1, 8'h77, 1'b0);
        applyStimulus(1'b1, 8'h78, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        check("reset_first_read", 32'(last_read), 32'h77);
        applyStimulus(1'b0, 8'h00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_sync_flags.md
FIFO_SYNC_FLAGS -- requirements
Module: fifo_sync_flags

Interface
REQ-001 Parameters SHALL be, one per line:
  DW  32  data width, 1..256
  DEPTH  16  entry count, any integer >= 2, power of two not required
  AFULL_TH  DEPTH-2  almost_full threshold, 1..DEPTH-1
  AEMPTY_TH  2  almost_empty threshold, 1..DEPTH-1
  OUT_REG  0  0 = head word combinational; 1 = registered read data
REQ-002 Ports SHALL be, one per line:
  clk  in  1  clock, all logic on rising edge
  rstn  in  1  reset, synchronous, active-low
  wr_en  in  1  write request
  data_in  in  DW  write data
  rd_en  in  1  read request
  data_out  out  DW  read data
  rd_valid  out  1  data_out qualifier
  empty  out  1  level == 0
  full  out  1  level == DEPTH
  almost_empty  out  1  level <= AEMPTY_TH
  almost_full  out  1  level >= AFULL_TH
  level  out  AW+1  current occupancy, AW = $clog2(DEPTH)
  overflow  out  1  one-cycle pulse, rejected write
  underflow  out  1  one-cycle pulse, rejected read

Function
REQ-003 Read accepted (rd_acc) SHALL be rd_en && !empty; otherwise rd_en SHALL pulse underflow the next cycle with no state change.
REQ-004 Write accepted (wr_acc) SHALL be wr_en && (!full || rd_acc); otherwise wr_en SHALL pulse overflow the next cycle with memory unchanged.
REQ-005 Full plus simultaneous wr_en/rd_en SHALL accept both; level stays DEPTH.
REQ-006 Empty plus simultaneous wr_en/rd_en SHALL accept the write only; level goes to 1; underflow pulses.
REQ-007 wr_acc SHALL store data_in at wr_ptr; wr_ptr SHALL advance by 1 and wrap from DEPTH-1 to 0.
REQ-008 rd_acc SHALL advance rd_ptr by 1 with identical wrap.
REQ-009 level SHALL be +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither; it never exceeds DEPTH and never goes below 0.
REQ-010 All flags SHALL be combinational decodes of registered level, valid the cycle after the causing edge.
REQ-011 OUT_REG=0: data_out SHALL equal mem[rd_ptr] combinationally; rd_valid SHALL equal !empty; a written word is visible at the head one cycle after wr_acc.
REQ-012 OUT_REG=1: on rd_acc, data_out SHALL load mem[rd_ptr] and rd_valid SHALL be 1 for exactly the next cycle; data_out SHALL hold otherwise; latency is 1 cycle.
REQ-013 Read data order SHALL be strict write order across any number of wraps.
REQ-014 Out-of-range parameters SHALL cause an elaboration-time error (DEPTH<2, thresholds outside 1..DEPTH-1).

Reset
REQ-015 When rstn=0 at a clock edge, wr_ptr, rd_ptr and level SHALL go to 0, overflow/underflow/rd_valid to 0, and data_out to 0 when OUT_REG=1.
REQ-016 After reset, empty=1, almost_empty=1, full=0, almost_full=0.
REQ-017 Memory contents SHALL NOT be reset; reset mid-operation discards all stored words; wr_en/rd_en during reset SHALL be ignored and raise no error pulse.

Structure
REQ-018 Shared package fifo_pkg SHALL hold the parameter-check function and the default threshold constants.
REQ-019 One sub-module, fifo_wrap_ptr (AW-bit pointer with increment-and-wrap at a programmable limit), SHALL be instantiated twice, for write and for read.

Verification
REQ-020 Benches SHALL use DW=8, DEPTH=5, AFULL_TH=4, AEMPTY_TH=1, both OUT_REG values, and cover:
  - Write 0x11..0x15 -> full=1, level=5, almost_full set at level 4; sixth write 0x16 -> overflow pulse, the word is not stored.
  - Read 5 words -> 0x11..0x15 in order, empty=1; extra read -> underflow pulse, level stays 0.
  - 12 write/read pairs with 2 words resident -> pointers wrap twice, order preserved, no error pulses.
  - At full, simultaneous wr_en/rd_en with 0xAA -> level=5, 0xAA emerges last.
  - At empty, simultaneous wr_en/rd_en with 0x3C -> level=1, underflow=1, head=0x3C.
  - rstn low with 3 words stored -> level=0, empty=1; the next write 0x77 is read first.
